// File: rtl/tx_mac_fifo.sv
// tx_mac_fifo: dual-clock, width-converting transmit FIFO feeding an Ethernet MAC.
// The core writes IN_WIDTH-bit words of N = IN_WIDTH/9 {eop, byte} lanes on clk.
// The MAC pops one lane per rd_clk, starting with the most-significant lane.
// Optional feature macro: TX_MAC_FIFO_ERR_FLAGS_EN enables the sticky
// wr_overflow / rd_underflow flags (tied low when undefined).
// Hold reset for at least three rd_clk periods so the read domain sees it.
module tx_mac_fifo #(
    parameter int IN_WIDTH  = 72,
    parameter int DEPTH     = 512,
    parameter int AF_MARGIN = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                rd_clk,
    input  logic [IN_WIDTH-1:0] din,
    input  logic                wr_en,
    output logic                full,
    output logic                almost_full,
    output logic                wr_overflow,
    output logic [8:0]          dout,
    input  logic                rd_en,
    output logic                empty,
    output logic                rd_underflow
);
    localparam int N  = IN_WIDTH / 9;
    localparam int LW = $clog2(N);
    localparam int AW = $clog2(DEPTH);
    localparam int RW = AW + LW;

    // word pointers carry one extra wrap bit
    typedef logic [AW:0] wptr_t;

    function automatic wptr_t bin2gray(input wptr_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic wptr_t gray2bin(input wptr_t g);
        wptr_t b;
        b[AW] = g[AW];
        for (int i = AW - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [IN_WIDTH-1:0] mem [DEPTH];

    // write domain
    wptr_t wr_ptr, wr_ptr_nxt, wr_gray;
    wptr_t rd_gray_p1, rd_gray_p2, rd_bin_wr, occupancy;
    logic  rst_hold, wr_fire;

    // read domain
    logic [RW:0]         rd_ptr, rd_ptr_nxt;
    wptr_t               rd_word, rd_gray, wr_gray_p1, wr_gray_p2;
    logic                rd_rst_p1, rd_rst_p2, rd_fire;
    logic [LW-1:0]       lane_idx;
    logic [IN_WIDTH-1:0] rd_data;
    logic [8:0]          rd_lane;

    assign wr_fire    = wr_en && !full;
    assign wr_ptr_nxt = wr_ptr + 1'b1;

    // store the incoming word; no write can happen while reset holds full high
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    // write pointer, its Gray image, and the two-flop sync of the read word pointer
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            wr_gray    <= '0;
            rst_hold   <= 1'b1;
            rd_gray_p1 <= '0;
            rd_gray_p2 <= '0;
        end else begin
            rst_hold   <= 1'b0;
            rd_gray_p1 <= rd_gray;
            rd_gray_p2 <= rd_gray_p1;
            if (wr_fire) begin
                wr_ptr  <= wr_ptr_nxt;
                wr_gray <= bin2gray(wr_ptr_nxt);
            end
        end
    end

    // occupancy against the synced read word pointer; both flags forced high around reset
    always_comb begin
        rd_bin_wr   = gray2bin(rd_gray_p2);
        occupancy   = wr_ptr - rd_bin_wr;
        full        = reset || rst_hold || (occupancy == wptr_t'(DEPTH));
        almost_full = reset || rst_hold || (occupancy >= wptr_t'(DEPTH - AF_MARGIN));
    end

    // bring reset into the read domain
    always_ff @(posedge rd_clk) begin
        rd_rst_p1 <= reset;
        rd_rst_p2 <= rd_rst_p1;
    end

    assign rd_word    = rd_ptr[RW:LW];
    assign lane_idx   = rd_ptr[LW-1:0];
    assign rd_ptr_nxt = rd_ptr + 1'b1;
    assign rd_fire    = rd_en && !empty;
    assign rd_data    = mem[rd_word[AW-1:0]];

    // empty when every written word has been fully consumed
    always_comb begin
        empty = rd_rst_p2 || (bin2gray(rd_word) == wr_gray_p2);
    end

    // lane counter 0 selects the top lane, so the word unloads MSB lane first
    always_comb begin
        rd_lane = '0;
        for (int i = 0; i < N; i++) begin
            if (lane_idx == LW'(N - 1 - i)) begin
                rd_lane = rd_data[9*i +: 9];
            end
        end
    end

    // lane pointer, registered output, and Gray word pointer published to the write side;
    // the word pointer only moves after lane 0, so a word frees when fully read
    always_ff @(posedge rd_clk) begin
        if (rd_rst_p2) begin
            rd_ptr     <= '0;
            rd_gray    <= '0;
            wr_gray_p1 <= '0;
            wr_gray_p2 <= '0;
            dout       <= '0;
        end else begin
            wr_gray_p1 <= wr_gray;
            wr_gray_p2 <= wr_gray_p1;
            if (rd_fire) begin
                rd_ptr  <= rd_ptr_nxt;
                rd_gray <= bin2gray(rd_ptr_nxt[RW:LW]);
                dout    <= rd_lane;
            end
        end
    end

`ifdef TX_MAC_FIFO_ERR_FLAGS_EN
    // sticky: a write was attempted while full
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_overflow <= 1'b0;
        end else if (wr_en && full) begin
            wr_overflow <= 1'b1;
        end
    end

    // sticky: a read was attempted while empty
    always_ff @(posedge rd_clk) begin
        if (rd_rst_p2) begin
            rd_underflow <= 1'b0;
        end else if (rd_en && empty) begin
            rd_underflow <= 1'b1;
        end
    end
`else
    assign wr_overflow  = 1'b0;
    assign rd_underflow = 1'b0;
`endif

endmodule

// File: tb/tb_tx_mac_fifo.sv
// tb_tx_mac_fifo: directed bench for tx_mac_fifo (IN_WIDTH=72, DEPTH=512).
// Follows TX_MAC_FIFO_ERR_FLAGS_EN when choosing the expected error-flag values.
module tb_tx_mac_fifo;
    logic        clk = 1'b0;
    logic        rd_clk = 1'b0;
    logic        reset = 1'b1;
    logic [71:0] din = '0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic        full, almost_full, wr_overflow, empty, rd_underflow;
    logic [8:0]  dout;

    int n_checks = 0;
    int n_fail   = 0;
    int rd_half  = 7;

`ifdef TX_MAC_FIFO_ERR_FLAGS_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    tx_mac_fifo #(.IN_WIDTH(72), .DEPTH(512), .AF_MARGIN(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .rd_clk       (rd_clk),
        .din          (din),
        .wr_en        (wr_en),
        .full         (full),
        .almost_full  (almost_full),
        .wr_overflow  (wr_overflow),
        .dout         (dout),
        .rd_en        (rd_en),
        .empty        (empty),
        .rd_underflow (rd_underflow)
    );

    always #5 clk = ~clk;
    always #(rd_half) rd_clk = ~rd_clk;

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // lane value by read-order index k; lane 0 of each word (k%8==7) carries eop
    function automatic logic [8:0] lane_val(input int k);
        logic [7:0] b;
        logic       e;
        b = 8'((k * 37) ^ (k >> 5));
        e = ((k % 8) == 7);
        return {e, b};
    endfunction

    function automatic logic [71:0] make_word(input int w);
        logic [71:0] v;
        for (int l = 0; l < 8; l++) begin
            v[9*l +: 9] = lane_val(w * 8 + 7 - l);
        end
        return v;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        repeat (10) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic write_word(input logic [71:0] w);
        @(posedge clk);
        #1 wr_en = 1'b1;
        din = w;
        @(posedge clk);
        #1 wr_en = 1'b0;
    endtask

    task automatic read_lane(output logic [8:0] v);
        int n = 0;
        while (empty && n < 50) begin
            @(posedge rd_clk);
            #1 n++;
        end
        if (empty) check_eq("rd_avail", 32'(empty), 32'd0);
        rd_en = 1'b1;
        @(posedge rd_clk);
        #1 rd_en = 1'b0;
        v = dout;
    endtask

    task automatic stream_write(input int base_w, input int nwords, input int limit);
        int sent = 0;
        for (int c = 0; c < limit && sent < nwords; c++) begin
            @(posedge clk);
            #1;
            if (!full) begin
                wr_en = 1'b1;
                din = make_word(base_w + sent);
                sent++;
            end else begin
                wr_en = 1'b0;
            end
        end
        @(posedge clk);
        #1 wr_en = 1'b0;
        check_eq("stream_sent", 32'(sent), 32'(nwords));
    endtask

    task automatic stream_read(input int base_k, input int nlanes, input int limit);
        int got = 0;
        int issued = 0;
        bit pend = 0;
        for (int c = 0; c < limit && got < nlanes; c++) begin
            @(posedge rd_clk);
            #1;
            if (pend) begin
                check_eq("stream_lane", 32'(dout), 32'(lane_val(base_k + got)));
                got++;
            end
            if (issued < nlanes && !empty) begin
                rd_en = 1'b1;
                pend = 1'b1;
                issued++;
            end else begin
                rd_en = 1'b0;
                pend = 1'b0;
            end
        end
        rd_en = 1'b0;
        check_eq("stream_got", 32'(got), 32'(nlanes));
    endtask

    initial begin
        logic [8:0]  v;
        logic [8:0]  exp_l [8];
        logic [71:0] w;
        int          n;

        // reset and idle
        repeat (6) @(posedge clk);
        #1;
        check_eq("rst_full", 32'(full), 32'd1);
        check_eq("rst_afull", 32'(almost_full), 32'd1);
        check_eq("rst_empty", 32'(empty), 32'd1);
        check_eq("rst_dout", 32'(dout), 32'h000);
        reset = 1'b0;
        check_eq("rst_full_hold", 32'(full), 32'd1);
        @(posedge clk);
        #1;
        check_eq("rel_full", 32'(full), 32'd0);
        check_eq("rel_afull", 32'(almost_full), 32'd0);
        repeat (5) @(posedge rd_clk);
        #1;
        check_eq("idle_empty", 32'(empty), 32'd1);
        check_eq("idle_dout", 32'(dout), 32'h000);
        check_eq("idle_ovf", 32'(wr_overflow), 32'd0);
        check_eq("idle_udf", 32'(rd_underflow), 32'd0);

        // one word, lanes 7..0 read MSB first
        exp_l[0] = 9'h0AA; exp_l[1] = 9'h0BB; exp_l[2] = 9'h0CC; exp_l[3] = 9'h0DD;
        exp_l[4] = 9'h0EE; exp_l[5] = 9'h011; exp_l[6] = 9'h022; exp_l[7] = 9'h1FF;
        write_word({9'h0AA, 9'h0BB, 9'h0CC, 9'h0DD, 9'h0EE, 9'h011, 9'h022, 9'h1FF});
        n = 0;
        while (empty && n < 10) begin
            @(posedge rd_clk);
            #1 n++;
        end
        check_eq("wr2rd_lat_le3", 32'(n <= 3), 32'd1);
        for (int i = 0; i < 8; i++) begin
            read_lane(v);
            check_eq("word_lane", 32'(v), 32'(exp_l[i]));
        end
        check_eq("word_empty", 32'(empty), 32'd1);

        // read while empty: dout holds
        rd_en = 1'b1;
        @(posedge rd_clk);
        #1 rd_en = 1'b0;
        check_eq("udf_dout_hold", 32'(dout), 32'h1FF);
        check_eq("udf_flag", 32'(rd_underflow), 32'(ERR_EXP));

        // fill to full, then one dropped write
        for (int j = 0; j < 512; j++) begin
            write_word(make_word(1000 + j));
            if (j == 506) check_eq("afull_507", 32'(almost_full), 32'd0);
            if (j == 507) check_eq("afull_508", 32'(almost_full), 32'd1);
            if (j == 510) check_eq("full_511", 32'(full), 32'd0);
            if (j == 511) check_eq("full_512", 32'(full), 32'd1);
        end
        check_eq("ovf_before", 32'(wr_overflow), 32'd0);
        write_word(make_word(1000 + 512));
        check_eq("ovf_flag", 32'(wr_overflow), 32'(ERR_EXP));
        check_eq("ovf_full", 32'(full), 32'd1);

        // seven lanes do not free the word
        for (int i = 0; i < 7; i++) begin
            read_lane(v);
            check_eq("fill_lane", 32'(v), 32'(lane_val(1000 * 8 + i)));
        end
        repeat (6) @(posedge clk);
        #1;
        check_eq("full_after7", 32'(full), 32'd1);
        read_lane(v);
        check_eq("fill_lane0", 32'(v), 32'(lane_val(1000 * 8 + 7)));
        n = 0;
        while (full && n < 10) begin
            @(posedge clk);
            #1 n++;
        end
        check_eq("free_lat_le3", 32'(n <= 3), 32'd1);

        // drain the rest; the dropped word must not appear
        for (int k = 8; k < 512 * 8; k++) begin
            read_lane(v);
            check_eq("drain_lane", 32'(v), 32'(lane_val(1000 * 8 + k)));
        end
        check_eq("drain_empty", 32'(empty), 32'd1);

        // continuous streaming, slow reader then fast reader
        rd_half = 50;
        fork
            stream_write(5000, 200, 25000);
            stream_read(5000 * 8, 1600, 3000);
        join
        rd_half = 3;
        fork
            stream_write(7000, 200, 2000);
            stream_read(7000 * 8, 1600, 4000);
        join
        rd_half = 7;
        repeat (4) @(posedge rd_clk);
        #1;
        check_eq("stream_empty", 32'(empty), 32'd1);

        // reset with data inside discards it
        write_word(make_word(9000));
        write_word(make_word(9001));
        repeat (5) @(posedge rd_clk);
        #1;
        check_eq("pre_rst_empty", 32'(empty), 32'd0);
        do_reset();
        repeat (6) @(posedge rd_clk);
        #1;
        check_eq("mid_rst_empty", 32'(empty), 32'd1);
        check_eq("mid_rst_dout", 32'(dout), 32'h000);
        check_eq("mid_rst_full", 32'(full), 32'd0);
        check_eq("mid_rst_ovf", 32'(wr_overflow), 32'd0);
        check_eq("mid_rst_udf", 32'(rd_underflow), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
